harmonic_scheduler: RTL and testbench

HARMONIC_SCHEDULER -- requirements
Module: harmonic_scheduler

---
 rtl/harmonic_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_harmonic_scheduler.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/harmonic_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : harmonic_scheduler
//  Description : Sequences up to three harmonics of a note through a shared
//                harmonic engine, sums the engine results into an 18-bit
//                accumulator and publishes one saturated 16-bit mixed sample
//                per request.
//  Revision    : 1.0 - initial release
// ============================================================================
module harmonic_scheduler #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        play_enable,
    input  logic        generate_next_sample,
    input  logic [19:0] step_size,
    input  logic [2:0]  harm_en,
    input  logic [5:0]  harm_weight,
    output logic        eng_go,
    output logic [1:0]  eng_sel,
    output logic [19:0] eng_step_size,
    output logic [1:0]  eng_weight,
    input  logic [15:0] eng_sample,
    input  logic        eng_ready,
    output logic [15:0] mix_out,
    output logic        sample_ready,
    output logic        busy,
    output logic        overrun,
    output logic        timeout_err
);

    // Wait counter runs 0 .. TIMEOUT-1; the last value ends the wait.
    localparam int c_cnt_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_NEXT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    logic [1:0]          r_k;
    logic signed [17:0]  r_acc;
    logic [c_cnt_w-1:0]  r_wait_cnt;

    logic [2:0]          w_above;
    logic [2:0]          w_first;
    logic [2:0]          w_next;
    logic [2:0]          w_load;
    logic [1:0]          w_load_k;
    logic                w_load_hit;
    logic [19:0]         w_load_step;
    logic [1:0]          w_load_weight;
    logic [15:0]         w_sat;

    // Returns {hit, k} for the lowest set bit of the mask.
    function automatic logic [2:0] pick_lowest(input logic [2:0] m);
        if (m[0])      return 3'b100;
        else if (m[1]) return 3'b101;
        else if (m[2]) return 3'b110;
        else           return 3'b000;
    endfunction

    assign busy = (r_state != S_IDLE);

    // Harmonic selection, per-harmonic engine operands and output saturation.
    always_comb begin
        w_above       = 3'b000;
        w_load_step   = step_size;
        w_load_weight = harm_weight[1:0];
        w_sat         = r_acc[15:0];

        case (r_k)
            2'd0:    w_above = 3'b110;
            2'd1:    w_above = 3'b100;
            default: w_above = 3'b000;
        endcase

        w_first    = pick_lowest(harm_en);
        w_next     = pick_lowest(harm_en & w_above);
        w_load     = (r_state == S_IDLE) ? w_first : w_next;
        w_load_k   = w_load[1:0];
        w_load_hit = w_load[2];

        // Multiply by (k+1) with shifts and one add, truncated to 20 bits.
        case (w_load_k)
            2'd0: begin
                w_load_step   = step_size;
                w_load_weight = harm_weight[1:0];
            end
            2'd1: begin
                w_load_step   = {step_size[18:0], 1'b0};
                w_load_weight = harm_weight[3:2];
            end
            default: begin
                w_load_step   = step_size + {step_size[18:0], 1'b0};
                w_load_weight = harm_weight[5:4];
            end
        endcase

        if (r_acc > 18'sd32767)
            w_sat = 16'h7FFF;
        else if (r_acc < -18'sd32768)
            w_sat = 16'h8000;
    end

    // Sequencer: issues each enabled harmonic, collects results, publishes the mix.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_k           <= 2'd0;
            r_acc         <= '0;
            r_wait_cnt    <= '0;
            eng_go        <= 1'b0;
            eng_sel       <= 2'd0;
            eng_step_size <= 20'd0;
            eng_weight    <= 2'd0;
            mix_out       <= 16'd0;
            sample_ready  <= 1'b0;
            overrun       <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            eng_go       <= 1'b0;
            sample_ready <= 1'b0;

            if (generate_next_sample && (r_state != S_IDLE))
                overrun <= 1'b1;

            if ((r_state != S_IDLE) && !play_enable) begin
                // Note released mid-sequence: abandon the sample entirely.
                r_state <= S_IDLE;
                r_acc   <= '0;
                mix_out <= 16'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (generate_next_sample) begin
                            if (!play_enable) begin
                                mix_out      <= 16'd0;
                                sample_ready <= 1'b1;
                            end else begin
                                r_acc <= '0;
                                if (w_load_hit) begin
                                    r_state       <= S_ISSUE;
                                    r_k           <= w_load_k;
                                    eng_go        <= 1'b1;
                                    eng_sel       <= w_load_k;
                                    eng_step_size <= w_load_step;
                                    eng_weight    <= w_load_weight;
                                end else begin
                                    r_state <= S_DONE;
                                end
                            end
                        end
                    end
                    S_ISSUE: begin
                        r_state    <= S_WAIT;
                        r_wait_cnt <= '0;
                    end
                    S_WAIT: begin
                        if (eng_ready) begin
                            r_acc   <= r_acc + {{2{eng_sample[15]}}, eng_sample};
                            r_state <= S_NEXT;
                        end else if (r_wait_cnt == c_last) begin
                            timeout_err <= 1'b1;
                            r_state     <= S_NEXT;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 1'b1;
                        end
                    end
                    S_NEXT: begin
                        if (w_load_hit) begin
                            r_state       <= S_ISSUE;
                            r_k           <= w_load_k;
                            eng_go        <= 1'b1;
                            eng_sel       <= w_load_k;
                            eng_step_size <= w_load_step;
                            eng_weight    <= w_load_weight;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        mix_out      <= w_sat;
                        sample_ready <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_harmonic_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_harmonic_scheduler
//  Description : Self-checking bench for harmonic_scheduler with a behavioural
//                engine responder and a sum/saturate/latency reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_harmonic_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        play_enable = 1'b1;
    logic        generate_next_sample = 1'b0;
    logic [19:0] step_size = 20'd0;
    logic [2:0]  harm_en = 3'd0;
    logic [5:0]  harm_weight = 6'd0;
    logic        eng_go;
    logic [1:0]  eng_sel;
    logic [19:0] eng_step_size;
    logic [1:0]  eng_weight;
    logic [15:0] eng_sample = 16'd0;
    logic        eng_ready = 1'b0;
    logic [15:0] mix_out;
    logic        sample_ready;
    logic        busy;
    logic        overrun;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    // Engine behaviour per harmonic: latency 0 means the engine never answers.
    int          eng_lat[3];
    logic [15:0] eng_val[3];
    logic [1:0]  q_sel[$];
    logic [19:0] q_step[$];
    logic [1:0]  q_w[$];

    harmonic_scheduler #(.TIMEOUT(255)) dut (
        .clk                  (clk),
        .reset                (reset),
        .play_enable          (play_enable),
        .generate_next_sample (generate_next_sample),
        .step_size            (step_size),
        .harm_en              (harm_en),
        .harm_weight          (harm_weight),
        .eng_go               (eng_go),
        .eng_sel              (eng_sel),
        .eng_step_size        (eng_step_size),
        .eng_weight           (eng_weight),
        .eng_sample           (eng_sample),
        .eng_ready            (eng_ready),
        .mix_out              (mix_out),
        .sample_ready         (sample_ready),
        .busy                 (busy),
        .overrun              (overrun),
        .timeout_err          (timeout_err)
    );

    always #5 clk = ~clk;

    // Shared engine model: logs every start pulse and answers L cycles later.
    always @(negedge clk) begin : engine
        int k;
        if (eng_go === 1'b1) begin
            q_sel.push_back(eng_sel);
            q_step.push_back(eng_step_size);
            q_w.push_back(eng_weight);
            k = int'(eng_sel);
            if (k < 3 && eng_lat[k] > 0) begin
                eng_sample = $urandom;
                repeat (eng_lat[k]) @(negedge clk);
                eng_sample = eng_val[k];
                eng_ready  = 1'b1;
                @(negedge clk);
                eng_ready  = 1'b0;
                eng_sample = $urandom;
            end
        end
    end

    // Pulses a request and returns the cycle count until sample_ready.
    task automatic run_req(input int budget, output int lat, output bit got);
        q_sel.delete(); q_step.delete(); q_w.delete();
        generate_next_sample = 1'b1;
        lat = 0;
        got = 1'b0;
        for (int i = 1; i <= budget && !got; i++) begin
            @(negedge clk);
            generate_next_sample = 1'b0;
            if (sample_ready === 1'b1) begin
                lat = i;
                got = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({eng_go, eng_sel, eng_step_size, eng_weight, mix_out, sample_ready, busy, overrun, timeout_err} !== 45'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h expected 0", {eng_go, eng_sel, eng_step_size, eng_weight, mix_out, sample_ready, busy, overrun, timeout_err});
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        int lat; bit got;
        step_size = 20'd500; harm_en = 3'b111; harm_weight = 6'b10_01_11;
        eng_lat = '{3, 3, 3};
        eng_val = '{16'd1000, 16'd2000, 16'd3000};
        run_req(100, lat, got);
        checks++;
        if (!got || lat != 17) begin
            errors++; $display("FAIL directed_latency got=%0d (seen %0b) expected 17", lat, got);
        end
        checks++;
        if (mix_out !== 16'd6000) begin
            errors++; $display("FAIL directed_mix got=%0d expected 6000", $signed(mix_out));
        end
        checks++;
        if (q_step.size() != 3) begin
            errors++; $display("FAIL directed_go_count got=%0d expected 3", q_step.size());
        end else if (q_step[0] !== 20'd500 || q_step[1] !== 20'd1000 || q_step[2] !== 20'd1500 ||
                     q_sel[0] !== 2'd0 || q_sel[1] !== 2'd1 || q_sel[2] !== 2'd2 ||
                     q_w[0] !== 2'b11 || q_w[1] !== 2'b01 || q_w[2] !== 2'b10) begin
            errors++;
            $display("FAIL directed_operands got step %0d/%0d/%0d sel %0d%0d%0d w %0d%0d%0d expected 500/1000/1500 sel 012 w 312",
                     q_step[0], q_step[1], q_step[2], q_sel[0], q_sel[1], q_sel[2], q_w[0], q_w[1], q_w[2]);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL directed_busy_after got=%0b expected 0", busy);
        end
    endtask

    task automatic test_saturation();
        int lat; bit got;
        harm_en = 3'b101; eng_lat = '{2, 2, 2};
        eng_val = '{16'd20000, 16'd0, 16'd20000};
        run_req(100, lat, got);
        checks++;
        if (!got || mix_out !== 16'h7FFF) begin
            errors++; $display("FAIL sat_pos got=%0d expected 32767", $signed(mix_out));
        end
        eng_val = '{-16'sd20000, 16'd0, -16'sd20000};
        run_req(100, lat, got);
        checks++;
        if (!got || mix_out !== 16'h8000) begin
            errors++; $display("FAIL sat_neg got=%0d expected -32768", $signed(mix_out));
        end
    endtask

    task automatic test_empty_and_play_off();
        int lat; bit got;
        play_enable = 1'b0; harm_en = 3'b111;
        run_req(20, lat, got);
        checks++;
        if (!got || lat != 1 || mix_out !== 16'd0 || q_sel.size() != 0) begin
            errors++; $display("FAIL play_off got lat=%0d mix=%0d gos=%0d expected lat=1 mix=0 gos=0", lat, mix_out, q_sel.size());
        end
        play_enable = 1'b1; harm_en = 3'b000;
        run_req(20, lat, got);
        checks++;
        if (!got || lat != 2 || mix_out !== 16'd0 || q_sel.size() != 0) begin
            errors++; $display("FAIL no_harmonics got lat=%0d mix=%0d gos=%0d expected lat=2 mix=0 gos=0", lat, mix_out, q_sel.size());
        end
    endtask

    task automatic test_overrun();
        int cnt, first;
        harm_en = 3'b001; eng_lat = '{2, 2, 2}; eng_val = '{16'd1234, 16'd0, 16'd0};
        cnt = 0; first = 0;
        generate_next_sample = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            generate_next_sample = (i == 3);
            if (sample_ready === 1'b1) begin
                cnt++;
                if (first == 0) first = i;
            end
        end
        checks++;
        if (cnt != 1 || first != 6) begin
            errors++; $display("FAIL overrun_single_sample got count=%0d first=%0d expected 1 at 6", cnt, first);
        end
        checks++;
        if (overrun !== 1'b1 || mix_out !== 16'd1234) begin
            errors++; $display("FAIL overrun_flag got ovr=%0b mix=%0d expected ovr=1 mix=1234", overrun, mix_out);
        end
    endtask

    task automatic test_play_drop();
        int cnt;
        harm_en = 3'b001; eng_lat = '{10, 10, 10}; eng_val = '{16'd555, 16'd0, 16'd0};
        generate_next_sample = 1'b1;
        @(negedge clk); generate_next_sample = 1'b0;
        @(negedge clk); @(negedge clk);
        play_enable = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mix_out !== 16'd0) begin
            errors++; $display("FAIL play_drop got busy=%0b mix=%0d expected busy=0 mix=0", busy, mix_out);
        end
        play_enable = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sample_ready === 1'b1) cnt++;
        end
        checks++;
        if (cnt != 0 || busy !== 1'b0 || mix_out !== 16'd0) begin
            errors++; $display("FAIL play_drop_quiet got ready_count=%0d busy=%0b mix=%0d expected 0 0 0", cnt, busy, mix_out);
        end
    endtask

    task automatic test_timeout();
        int lat; bit got;
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++; $display("FAIL timeout_pre got=%0b expected 0", timeout_err);
        end
        harm_en = 3'b001; eng_lat = '{0, 0, 0};
        run_req(400, lat, got);
        checks++;
        if (!got || lat != 259 || timeout_err !== 1'b1 || mix_out !== 16'd0) begin
            errors++; $display("FAIL timeout_single got lat=%0d err=%0b mix=%0d expected 259 1 0", lat, timeout_err, mix_out);
        end
        harm_en = 3'b011; eng_lat = '{0, 2, 0}; eng_val = '{16'd0, 16'd777, 16'd0};
        run_req(400, lat, got);
        checks++;
        if (!got || lat != 263 || mix_out !== 16'd777) begin
            errors++; $display("FAIL timeout_then_answer got lat=%0d mix=%0d expected 263 777", lat, mix_out);
        end
    endtask

    task automatic test_reset_mid();
        int lat, cnt; bit got;
        harm_en = 3'b111; step_size = 20'd1000; eng_lat = '{10, 10, 10};
        generate_next_sample = 1'b1;
        @(negedge clk); generate_next_sample = 1'b0;
        @(negedge clk); @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({eng_go, eng_sel, eng_step_size, eng_weight, mix_out, sample_ready, busy, overrun, timeout_err} !== 45'd0) begin
            errors++;
            $display("FAIL reset_async got=%h expected 0", {eng_go, eng_sel, eng_step_size, eng_weight, mix_out, sample_ready, busy, overrun, timeout_err});
        end
        @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (sample_ready === 1'b1) cnt++;
        end
        checks++;
        if (cnt != 0) begin
            errors++; $display("FAIL reset_no_sample got=%0d expected 0", cnt);
        end
        eng_lat = '{2, 2, 2}; eng_val = '{16'd1, 16'd2, 16'd3};
        run_req(100, lat, got);
        checks++;
        if (!got || lat != 14 || mix_out !== 16'd6 || q_sel.size() != 3) begin
            errors++; $display("FAIL reset_resume got lat=%0d mix=%0d gos=%0d expected 14 6 3", lat, mix_out, q_sel.size());
        end
    endtask

    task automatic test_random();
        int lat, exp_lat, sum, n, t; bit got;
        logic [15:0] exp_mix;
        logic [19:0] exp_step;
        for (int it = 0; it < 25; it++) begin
            step_size   = 20'($urandom);
            harm_en     = 3'($urandom_range(0, 7));
            harm_weight = 6'($urandom);
            for (int k = 0; k < 3; k++) begin
                eng_lat[k] = $urandom_range(1, 6);
                eng_val[k] = 16'($urandom);
            end
            sum = 0; n = 0; exp_lat = 2;
            for (int k = 0; k < 3; k++) begin
                if (harm_en[k]) begin
                    sum += int'($signed(eng_val[k]));
                    exp_lat += eng_lat[k] + 2;
                    n++;
                end
            end
            if (sum > 32767) exp_mix = 16'h7FFF;
            else if (sum < -32768) exp_mix = 16'h8000;
            else exp_mix = 16'(sum);
            run_req(200, lat, got);
            checks++;
            if (!got || lat != exp_lat) begin
                errors++; $display("FAIL rand_latency it=%0d got=%0d expected %0d", it, lat, exp_lat);
            end
            checks++;
            if (mix_out !== exp_mix) begin
                errors++; $display("FAIL rand_mix it=%0d got=%0d expected %0d", it, $signed(mix_out), $signed(exp_mix));
            end
            checks++;
            if (q_sel.size() != n) begin
                errors++; $display("FAIL rand_go_count it=%0d got=%0d expected %0d", it, q_sel.size(), n);
            end else begin
                n = 0;
                for (int k = 0; k < 3; k++) begin
                    if (harm_en[k]) begin
                        t = int'(step_size) * (k + 1);
                        exp_step = t[19:0];
                        if (q_sel[n] !== 2'(k) || q_step[n] !== exp_step || q_w[n] !== harm_weight[2*k +: 2]) begin
                            errors++;
                            $display("FAIL rand_operands it=%0d k=%0d got sel=%0d step=%0d w=%0d expected sel=%0d step=%0d w=%0d",
                                     it, k, q_sel[n], q_step[n], q_w[n], k, exp_step, harm_weight[2*k +: 2]);
                        end
                        n++;
                    end
                end
            end
        end
    endtask

    initial begin
        eng_lat = '{1, 1, 1};
        eng_val = '{16'd0, 16'd0, 16'd0};
        @(negedge clk);
        test_reset();
        test_directed();
        test_saturation();
        test_empty_and_play_off();
        test_overrun();
        test_play_drop();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

endmodule
`default_nettype wire
